xb_mem8_initiator: RTL and testbench
====================================

Name: xb_mem8_initiator

Overview:
- Drives the 8-bit addressable-memory user interface (addr, addr_update, wren, rden, data) from the core side, acting as the initiator for a user memory that responds.
- Consumes 32-bit command words from a standard (non-FWFT) FIFO read port and executes them as seek, write, or read-burst operations.
- Returns read data through a standard-FIFO-style 8-bit response port.
- Used as an on-chip initiator to exercise user RAMs behind the mem_8 interface without the PCIe core.

Parameters:
- ADDR_W, 5, memory address width (1..8).
- RSP_DEPTH, 4, response buffer entries (power of 2, ≥2).

Ports:
- bus_clk  in  1  sole clock
- bus_rst_n  in  1  asynchronous active-low reset
- cmd_data  in  32  command word, valid the cycle after cmd_rden
- cmd_empty  in  1  command FIFO empty
- cmd_rden  out  1  command FIFO read strobe
- mem_addr  out  ADDR_W  current memory address
- mem_addr_update  out  1  one-cycle pulse when mem_addr is loaded by seek
- mem_wren  out  1  memory write strobe
- mem_wdata  out  8  write data, valid with mem_wren
- mem_rden  out  1  memory read strobe
- mem_rdata  in  8  read data, valid the cycle after mem_rden
- rsp_data  out  8  response data, updated the cycle after rsp_rden
- rsp_empty  out  1  response buffer empty
- rsp_rden  in  1  response read strobe
- busy  out  1  high when not in IDLE, or when reads are in flight
- err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Command format:
  - cmd[31:30] opcode: 00 write, 01 read burst, 10 seek, 11 illegal.
  - cmd[23:16] address; seek uses the low ADDR_W bits.
  - cmd[15:8] burst length minus 1, so 1..256 bytes.
  - cmd[7:0] write data.
- Reset values: all outputs 0 except rsp_empty=1. Address register, response buffer, state and err are all cleared.
- FSM states: IDLE, FETCH, DECODE, WRITE, READ.
  - IDLE: if cmd_empty=0, pulse cmd_rden for 1 cycle and go to FETCH.
  - FETCH: capture cmd_data into the command register, then go to DECODE.
  - DECODE, seek: load mem_addr, pulse mem_addr_update in the same cycle, return to IDLE.
  - DECODE, write: go to WRITE.
  - DECODE, read: load the remaining-count register = len+1, go to READ.
  - DECODE, illegal opcode: set err, drop the command, return to IDLE.
  - WRITE: mem_wren=1 for exactly one cycle with mem_wdata=cmd[7:0] at the current mem_addr; increment the address on the next edge; return to IDLE.
  - READ: each cycle, assert mem_rden only if (buffer occupancy + reads in flight) < RSP_DEPTH. Each issue increments the address and decrements the remaining count. When the count reaches 0, return to IDLE.
- Response capture: mem_rdata is written into the response buffer on the cycle after each mem_rden. The buffer never overflows, by construction of the credit check above.
- Throughput:
  - Minimum command latency is cmd_rden → first memory strobe = 3 cycles.
  - Sustained reads run at 1 byte/cycle while the consumer keeps rsp_rden high.
- Address increment never asserts mem_addr_update; only seek does.
- Address overflow (increment from 2^ADDR_W−1) follows the optional feature below.
- Response port boundaries:
  - rsp_rden while rsp_empty=1 is ignored; rsp_data holds its value.
  - Simultaneous buffer write and rsp_rden are both honoured; occupancy is unchanged.
- busy stays high until the last response of a read burst has been written into the buffer.
- Reset mid-burst: state returns to IDLE immediately and the buffer is flushed. The remainder of the burst is lost; the command FIFO is not re-read.
- mem_wren and mem_rden are never high in the same cycle.

Optional Feature:
- Macro: XB_MEM8_ADDR_WRAP_EN.
- Defined: the address wraps from 2^ADDR_W−1 to 0 with no error.
- Undefined: the address saturates at 2^ADDR_W−1 and err is set.
  - Later writes and reads in the same command still proceed at the saturated address.
  - A read burst still returns its full byte count.

Test Plan:
- Seek and write. Commands 0x8005_0000 (seek 5), then 0x0000_00A5 and 0x0000_003C. Required: mem_addr_update pulses once with mem_addr=5; mem_wren at addr 5 with data 0xA5, then at addr 6 with data 0x3C; final mem_addr=7.
- Read burst with stalled consumer. Seek 0, then 0x4000_0700 (8 bytes), with rsp_rden held low. Required: exactly 4 mem_rden issued (RSP_DEPTH=4), then a stall. Pulsing rsp_rden releases the remainder. The responder RAM returns addr+0x10, so rsp_data sequence = 0x10..0x17 and rsp_empty=1 at the end.
- Back-to-back. Read burst with rsp_rden held high continuously. Required: mem_rden asserted on 8 consecutive cycles; busy drops 1 cycle after the last response is captured.
- Illegal opcode 0xC000_0000. Required: err=1, no mem strobe, the next command is still processed.
- Wrap boundary. Seek 31, read 2 bytes. Required: addresses 31 then 0 with the macro defined; without it, addresses 31 then 31 and err=1.
- Reset mid-burst. Deassert bus_rst_n during a 16-byte read. Required: all strobes go 0 asynchronously; rsp_empty=1, busy=0, mem_addr=0.

Source files
------------

// File: rtl/xb_mem8_initiator.sv
// xb_mem8_initiator: executes 32-bit commands from a standard FIFO as seek,
// write or read-burst operations on an 8-bit addressable memory. Read data
// comes back through a small standard-FIFO-style response buffer.
// Optional build macro: XB_MEM8_ADDR_WRAP_EN (address wraps instead of
// saturating with err).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a command; pulses cmd_rden when one is available
// S_FETCH  | command word arrives on cmd_data; captured at end of cycle
// S_DECODE | seek loads the address, read loads the count, illegal -> err
// S_WRITE  | single write strobe at the current address
// S_READ   | issues reads while the response buffer has credit
module xb_mem8_initiator #(
  parameter int ADDR_W    = 5,
  parameter int RSP_DEPTH = 4
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_empty,
  output logic              cmd_rden,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_addr_update,
  output logic              mem_wren,
  output logic [7:0]        mem_wdata,
  output logic              mem_rden,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        rsp_data,
  output logic              rsp_empty,
  input  logic              rsp_rden,
  output logic              busy,
  output logic              err
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [PTR_W+1:0]  DEPTH_L  = (PTR_W+2)'(RSP_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_READ} state_t;

  state_t          state, state_nxt;
  logic [31:0]     cmd_reg;
  logic [8:0]      remain;
  logic            rd_pend;
  logic [PTR_W:0]  occ;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]      buf_mem [RSP_DEPTH];
  logic [PTR_W+1:0] credit_sum;
  logic            credit_ok;
  logic            seek_load, load_remain, set_illegal;
  logic            addr_step, addr_ovf;
  logic            buf_push, buf_pop;
  logic [1:0]      opcode;
  logic            unused_bits;

  assign opcode      = cmd_reg[31:30];
  assign unused_bits = ^cmd_reg[29:16];

  // Reads already issued but not yet captured count against buffer space,
  // so the buffer can never overflow.
  assign credit_sum = {1'b0, occ} + {{(PTR_W+1){1'b0}}, rd_pend};
  assign credit_ok  = credit_sum < DEPTH_L;

  assign addr_step = mem_wren | mem_rden;
`ifdef XB_MEM8_ADDR_WRAP_EN
  assign addr_ovf  = 1'b0;
`else
  assign addr_ovf  = addr_step && (mem_addr == ADDR_MAX);
`endif

  assign buf_push  = rd_pend;
  assign buf_pop   = rsp_rden && (occ != '0);
  assign rsp_empty = (occ == '0);
  assign busy      = (state != S_IDLE) || rd_pend;

  // State register.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt   = state;
    cmd_rden    = 1'b0;
    mem_wren    = 1'b0;
    mem_rden    = 1'b0;
    mem_wdata   = 8'h00;
    seek_load   = 1'b0;
    load_remain = 1'b0;
    set_illegal = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cmd_empty) begin
          cmd_rden  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          2'b00: state_nxt = S_WRITE;
          2'b01: begin
            load_remain = 1'b1;
            state_nxt   = S_READ;
          end
          2'b10: begin
            seek_load = 1'b1;
            state_nxt = S_IDLE;
          end
          default: begin
            set_illegal = 1'b1;
            state_nxt   = S_IDLE;
          end
        endcase
      end
      S_WRITE: begin
        mem_wren  = 1'b1;
        mem_wdata = cmd_reg[7:0];
        state_nxt = S_IDLE;
      end
      S_READ: begin
        if (credit_ok) begin
          mem_rden = 1'b1;
          if (remain == 9'd1) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command capture, burst count and read-in-flight tracking.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      cmd_reg <= '0;
      remain  <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= mem_rden;
      if (state == S_FETCH) cmd_reg <= cmd_data;
      if (load_remain)      remain  <= {1'b0, cmd_reg[15:8]} + 9'd1;
      else if (mem_rden)    remain  <= remain - 9'd1;
    end
  end

  // Address register: seek loads and pulses update, strobes post-increment.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      mem_addr        <= '0;
      mem_addr_update <= 1'b0;
    end else begin
      mem_addr_update <= seek_load;
      if (seek_load)                  mem_addr <= cmd_reg[16 +: ADDR_W];
      else if (addr_step && !addr_ovf) mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

  // Sticky error: illegal opcode or address overflow.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)                    err <= 1'b0;
    else if (set_illegal || addr_ovf)  err <= 1'b1;
  end

  // Response buffer storage; contents are don't-care once occupancy is flushed.
  always_ff @(posedge bus_clk) begin
    if (buf_push) buf_mem[wr_ptr] <= mem_rdata;
  end

  // Response buffer pointers, occupancy and registered read port.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      rsp_data <= 8'h00;
    end else begin
      if (buf_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (buf_pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        rsp_data <= buf_mem[rd_ptr];
      end
      case ({buf_push, buf_pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_xb_mem8_initiator.sv
// Directed testbench for xb_mem8_initiator (ADDR_W=5, RSP_DEPTH=4).
module tb_xb_mem8_initiator;
  localparam int ADDR_W    = 5;
  localparam int RSP_DEPTH = 4;

  logic              bus_clk = 1'b0;
  logic              bus_rst_n = 1'b0;
  logic [31:0]       cmd_data = '0;
  logic              cmd_empty;
  logic              cmd_rden;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_addr_update;
  logic              mem_wren;
  logic [7:0]        mem_wdata;
  logic              mem_rden;
  logic [7:0]        mem_rdata = '0;
  logic [7:0]        rsp_data;
  logic              rsp_empty;
  logic              rsp_rden = 1'b0;
  logic              busy;
  logic              err;

  int n_pass = 0;
  int n_total = 0;

  xb_mem8_initiator #(.ADDR_W(ADDR_W), .RSP_DEPTH(RSP_DEPTH)) u_dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .cmd_data(cmd_data), .cmd_empty(cmd_empty), .cmd_rden(cmd_rden),
    .mem_addr(mem_addr), .mem_addr_update(mem_addr_update),
    .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rden(mem_rden),
    .mem_rdata(mem_rdata), .rsp_data(rsp_data), .rsp_empty(rsp_empty),
    .rsp_rden(rsp_rden), .busy(busy), .err(err)
  );

  always #5 bus_clk = ~bus_clk;

  // Standard (non-FWFT) command FIFO model.
  logic [31:0] cmd_mem [64];
  int cmd_wp = 0;
  int cmd_rp = 0;
  assign cmd_empty = (cmd_wp == cmd_rp);
  always @(posedge bus_clk) begin
    if (cmd_rden && !cmd_empty) begin
      cmd_data <= cmd_mem[cmd_rp[5:0]];
      cmd_rp   <= cmd_rp + 1;
    end
  end

  // Responder RAM: read data is address + 0x10, one cycle after mem_rden.
  always @(posedge bus_clk) begin
    if (mem_rden) mem_rdata <= 8'h10 + 8'(mem_addr);
  end

  // Strobe monitor.
  int cyc = 0;
  int rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_data_q[$], wr_cyc_q[$];
  int upd_addr_q[$], crd_cyc_q[$];
  int both_cnt = 0;
  int last_busy_cyc = 0;
  logic [7:0] rsp_got[$];
  always @(posedge bus_clk) begin
    cyc <= cyc + 1;
    if (mem_rden) begin rd_addr_q.push_back(int'(mem_addr)); rd_cyc_q.push_back(cyc); end
    if (mem_wren) begin
      wr_addr_q.push_back(int'(mem_addr)); wr_data_q.push_back(int'(mem_wdata));
      wr_cyc_q.push_back(cyc);
    end
    if (mem_addr_update) upd_addr_q.push_back(int'(mem_addr));
    if (cmd_rden) crd_cyc_q.push_back(cyc);
    if (mem_wren && mem_rden) both_cnt <= both_cnt + 1;
    if (busy) last_busy_cyc <= cyc;
  end

  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    wr_cyc_q.delete(); upd_addr_q.delete(); crd_cyc_q.delete(); rsp_got.delete();
  endtask

  task automatic push(input logic [31:0] w);
    cmd_mem[cmd_wp[5:0]] = w;
    cmd_wp = cmd_wp + 1;
  endtask

  // Hold rsp_rden high, collect popped bytes, stop once everything is idle.
  task automatic drain(input int max, output bit ok);
    bit pop_pend;
    ok = 1'b0;
    rsp_rden = 1'b1;
    pop_pend = !rsp_empty;
    for (int i = 0; i < max; i++) begin
      @(negedge bus_clk);
      if (pop_pend) rsp_got.push_back(rsp_data);
      pop_pend = rsp_rden && !rsp_empty;
      if (!pop_pend && !busy && cmd_rp == cmd_wp) begin ok = 1'b1; break; end
    end
    rsp_rden = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge bus_clk);
    bus_rst_n = 1'b0;
    repeat (2) @(negedge bus_clk);
    bus_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus_rst_n = 1'b0;
    repeat (3) @(negedge bus_clk);
    n_total++; if ({cmd_rden, mem_addr_update, mem_wren, mem_rden} !== 4'b0000)
      $display("FAIL rst_strobes got=%b exp=0000", {cmd_rden, mem_addr_update, mem_wren, mem_rden}); else n_pass++;
    n_total++; if (mem_addr !== 5'd0) $display("FAIL rst_addr got=%0d exp=0", mem_addr); else n_pass++;
    n_total++; if ({rsp_empty, busy, err} !== 3'b100)
      $display("FAIL rst_flags got=%b exp=100", {rsp_empty, busy, err}); else n_pass++;
    n_total++; if ({mem_wdata, rsp_data} !== 16'h0000)
      $display("FAIL rst_data got=%h exp=0000", {mem_wdata, rsp_data}); else n_pass++;
    bus_rst_n = 1'b1;
    @(negedge bus_clk);
  endtask

  task automatic test_seek_write();
    bit ok;
    clear_logs();
    push(32'h8005_0000); push(32'h0000_00A5); push(32'h0000_003C);
    drain(100, ok);
    n_total++; if (!ok) $display("FAIL sw_timeout got=busy exp=idle"); else n_pass++;
    n_total++; if (upd_addr_q.size() !== 1 || upd_addr_q[0] !== 5)
      $display("FAIL sw_update got=%0d pulses exp=1 at addr 5", upd_addr_q.size()); else n_pass++;
    n_total++; if (wr_addr_q.size() !== 2) $display("FAIL sw_wr_count got=%0d exp=2", wr_addr_q.size()); else n_pass++;
    n_total++; if (wr_addr_q[0] !== 5 || wr_data_q[0] !== 'hA5)
      $display("FAIL sw_wr0 got=%0d/%h exp=5/a5", wr_addr_q[0], wr_data_q[0]); else n_pass++;
    n_total++; if (wr_addr_q[1] !== 6 || wr_data_q[1] !== 'h3C)
      $display("FAIL sw_wr1 got=%0d/%h exp=6/3c", wr_addr_q[1], wr_data_q[1]); else n_pass++;
    n_total++; if (mem_addr !== 5'd7) $display("FAIL sw_final_addr got=%0d exp=7", mem_addr); else n_pass++;
    n_total++; if (wr_cyc_q[0] - crd_cyc_q[1] !== 3)
      $display("FAIL sw_latency got=%0d exp=3", wr_cyc_q[0] - crd_cyc_q[1]); else n_pass++;
    n_total++; if (rd_addr_q.size() !== 0) $display("FAIL sw_no_reads got=%0d exp=0", rd_addr_q.size()); else n_pass++;
  endtask

  task automatic test_read_stall();
    bit ok;
    bit addr_ok;
    int k;
    clear_logs();
    rsp_rden = 1'b0;
    push(32'h8000_0000); push(32'h4000_0700);
    repeat (20) @(negedge bus_clk);
    n_total++; if (rd_addr_q.size() !== 4) $display("FAIL rs_credit got=%0d exp=4", rd_addr_q.size()); else n_pass++;
    n_total++; if ({busy, rsp_empty} !== 2'b10) $display("FAIL rs_stalled got=%b exp=10", {busy, rsp_empty}); else n_pass++;
    n_total++; if (rd_cyc_q[0] - crd_cyc_q[1] !== 3)
      $display("FAIL rs_latency got=%0d exp=3", rd_cyc_q[0] - crd_cyc_q[1]); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      k = 0;
      while (rsp_empty && k < 20) begin @(negedge bus_clk); k++; end
      rsp_rden = 1'b1;
      @(negedge bus_clk);
      rsp_rden = 1'b0;
      n_total++; if (rsp_data !== 8'h10 + 8'(i))
        $display("FAIL rs_data%0d got=%h exp=%h", i, rsp_data, 8'h10 + 8'(i)); else n_pass++;
    end
    drain(50, ok);
    n_total++; if (!ok || rsp_empty !== 1'b1) $display("FAIL rs_end got=ok%0d/empty%b exp=ok1/empty1", ok, rsp_empty); else n_pass++;
    addr_ok = (rd_addr_q.size() == 8);
    for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] != i) addr_ok = 1'b0;
    n_total++; if (!addr_ok) $display("FAIL rs_addrs got=%0d reads exp=8 reads at 0..7", rd_addr_q.size()); else n_pass++;
    n_total++; if (mem_addr !== 5'd8) $display("FAIL rs_final_addr got=%0d exp=8", mem_addr); else n_pass++;
  endtask

  task automatic test_empty_read();
    rsp_rden = 1'b1;
    @(negedge bus_clk);
    rsp_rden = 1'b0;
    @(negedge bus_clk);
    n_total++; if (rsp_data !== 8'h17 || rsp_empty !== 1'b1)
      $display("FAIL er_hold got=%h/%b exp=17/1", rsp_data, rsp_empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seq_ok;
    clear_logs();
    push(32'h8010_0000); push(32'h4000_0700);
    drain(100, ok);
    n_total++; if (!ok) $display("FAIL bb_timeout got=busy exp=idle"); else n_pass++;
    seq_ok = (rd_cyc_q.size() == 8);
    for (int i = 0; i < rd_cyc_q.size(); i++) if (rd_cyc_q[i] != rd_cyc_q[0] + i) seq_ok = 1'b0;
    n_total++; if (!seq_ok) $display("FAIL bb_consecutive got=%0d reads exp=8 consecutive", rd_cyc_q.size()); else n_pass++;
    seq_ok = (rsp_got.size() == 8);
    for (int i = 0; i < rsp_got.size(); i++) if (rsp_got[i] != 8'h20 + 8'(i)) seq_ok = 1'b0;
    n_total++; if (!seq_ok) $display("FAIL bb_data got=%0d bytes exp=8 bytes 20..27", rsp_got.size()); else n_pass++;
    n_total++; if (last_busy_cyc !== rd_cyc_q[7] + 1)
      $display("FAIL bb_busy_drop got=%0d exp=%0d", last_busy_cyc, rd_cyc_q[7] + 1); else n_pass++;
  endtask

  task automatic test_illegal();
    bit ok;
    clear_logs();
    push(32'hC000_0000); push(32'h0000_005A);
    drain(100, ok);
    n_total++; if (!ok || err !== 1'b1) $display("FAIL il_err got=ok%0d/err%b exp=ok1/err1", ok, err); else n_pass++;
    n_total++; if (wr_addr_q.size() !== 1 || rd_addr_q.size() !== 0 || upd_addr_q.size() !== 0)
      $display("FAIL il_strobes got=wr%0d/rd%0d/upd%0d exp=1/0/0", wr_addr_q.size(), rd_addr_q.size(), upd_addr_q.size()); else n_pass++;
    n_total++; if (wr_addr_q[0] !== 24 || wr_data_q[0] !== 'h5A)
      $display("FAIL il_next_cmd got=%0d/%h exp=24/5a", wr_addr_q[0], wr_data_q[0]); else n_pass++;
    n_total++; if (mem_addr !== 5'd25) $display("FAIL il_final_addr got=%0d exp=25", mem_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    int exp_a1, exp_fin;
    logic exp_err;
    logic [7:0] exp_d1;
`ifdef XB_MEM8_ADDR_WRAP_EN
    exp_a1 = 0;  exp_fin = 1;  exp_err = 1'b0; exp_d1 = 8'h10;
`else
    exp_a1 = 31; exp_fin = 31; exp_err = 1'b1; exp_d1 = 8'h2F;
`endif
    n_total++; if (err !== 1'b0) $display("FAIL wr_err_clear got=%b exp=0", err); else n_pass++;
    clear_logs();
    push(32'h801F_0000); push(32'h4000_0100);
    drain(100, ok);
    n_total++; if (!ok || rd_addr_q.size() !== 2) $display("FAIL wr_count got=%0d exp=2", rd_addr_q.size()); else n_pass++;
    n_total++; if (rd_addr_q[0] !== 31 || rd_addr_q[1] !== exp_a1)
      $display("FAIL wr_addrs got=%0d,%0d exp=31,%0d", rd_addr_q[0], rd_addr_q[1], exp_a1); else n_pass++;
    n_total++; if (err !== exp_err) $display("FAIL wr_err got=%b exp=%b", err, exp_err); else n_pass++;
    n_total++; if (rsp_got.size() !== 2 || rsp_got[0] !== 8'h2F || rsp_got[1] !== exp_d1)
      $display("FAIL wr_data got=%0d bytes exp=2f,%h", rsp_got.size(), exp_d1); else n_pass++;
    n_total++; if (mem_addr !== 5'(exp_fin)) $display("FAIL wr_final_addr got=%0d exp=%0d", mem_addr, exp_fin); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    int rp_snap, rd_snap;
    clear_logs();
    rsp_rden = 1'b1;
    push(32'h8000_0000); push(32'h4000_0F00);
    k = 0;
    while (!(mem_rden && rd_addr_q.size() >= 3) && k < 60) begin @(negedge bus_clk); k++; end
    n_total++; if (mem_rden !== 1'b1) $display("FAIL rm_midburst got=%b exp=1", mem_rden); else n_pass++;
    #2 bus_rst_n = 1'b0;
    #1;
    n_total++; if ({cmd_rden, mem_wren, mem_rden, mem_addr_update} !== 4'b0000)
      $display("FAIL rm_strobes got=%b exp=0000", {cmd_rden, mem_wren, mem_rden, mem_addr_update}); else n_pass++;
    n_total++; if ({rsp_empty, busy, err} !== 3'b100)
      $display("FAIL rm_flags got=%b exp=100", {rsp_empty, busy, err}); else n_pass++;
    n_total++; if (mem_addr !== 5'd0) $display("FAIL rm_addr got=%0d exp=0", mem_addr); else n_pass++;
    rp_snap = cmd_rp;
    rd_snap = rd_addr_q.size();
    repeat (3) @(negedge bus_clk);
    bus_rst_n = 1'b1;
    repeat (10) @(negedge bus_clk);
    n_total++; if (cmd_rp !== rp_snap || rd_addr_q.size() !== rd_snap)
      $display("FAIL rm_no_resume got=rp%0d/rd%0d exp=rp%0d/rd%0d", cmd_rp, rd_addr_q.size(), rp_snap, rd_snap); else n_pass++;
    n_total++; if ({busy, rsp_empty} !== 2'b01) $display("FAIL rm_idle got=%b exp=01", {busy, rsp_empty}); else n_pass++;
    rsp_rden = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seek_write();
    test_read_stall();
    test_empty_read();
    test_back_to_back();
    test_illegal();
    apply_reset();
    test_wrap();
    test_reset_mid();
    n_total++; if (both_cnt !== 0) $display("FAIL wr_rd_overlap got=%0d exp=0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
